// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: accepts a byte via valid/ready and serializes start, data (LSB first), optional parity, stop.
// Optional even-parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_W-1:0]      baud_div,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_d;
    logic [CNT_W-1:0]      div_r;
    logic [CNT_W-1:0]      div_d;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] shift_d;
    logic                  tx_d;
    logic                  done_d;
    logic                  ready_d;
    logic                  tick_c;
`ifdef UART_TX_PARITY_EN
    logic                  par_r;
    logic                  par_d;
`endif

    assign tick_c = (cnt_r == (div_r - CNT_W'(1)));

    // State and datapath registers; outputs are flopped from their next values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_r    <= '0;
            div_r    <= CNT_W'(1);
            bit_cnt  <= '0;
            shift_r  <= '0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_r    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_r    <= cnt_d;
            div_r    <= div_d;
            bit_cnt  <= bit_cnt_d;
            shift_r  <= shift_d;
            tx       <= tx_d;
            tx_ready <= ready_d;
            busy     <= ~ready_d;
            done     <= done_d;
`ifdef UART_TX_PARITY_EN
            par_r    <= par_d;
`endif
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d   = state_q;
        div_d     = div_r;
        bit_cnt_d = bit_cnt;
        shift_d   = shift_r;
        done_d    = 1'b0;
        cnt_d     = '0;
        tx_d      = 1'b1;
        ready_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_r;
`endif

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shift_d   = tx_data;
                    div_d     = (baud_div == '0) ? CNT_W'(1) : baud_div;
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    par_d     = ^tx_data;
`endif
                    state_d   = START;
                end
            end
            START: begin
                if (tick_c) state_d = DATA;
            end
            DATA: begin
                if (tick_c) begin
                    shift_d   = shift_r >> 1;
                    bit_cnt_d = bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick_c) state_d = STOP;
            end
`endif
            STOP: begin
                if (tick_c) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bit-period counter restarts on every state change and whenever a period elapses.
        if ((state_q != IDLE) && (state_d == state_q) && !tick_c) begin
            cnt_d = cnt_r + CNT_W'(1);
        end

        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase

        ready_d = (state_d == IDLE);
    end

endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

- Transmit-side controller for the UART datapath.
- Accepts a parallel byte through a valid/ready handshake and sequences a bit-period counter and a shift register to serialize it as one UART frame: start, data LSB first, optional parity, stop.
- Sits between the host-side command/data logic and the `tx` pin.
- Owns the only baud-period counter on the transmit path.

## Interface

Parameters:
- `DATA_WIDTH`, 8, number of data bits per frame.
- `CNT_W`, 16, width of the bit-period counter and of `baud_div`.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: synchronous, active-high reset; one clock, reset is synchronous and active-high.
- `baud_div` input CNT_W: clocks per bit; sampled at handshake acceptance; value 0 treated as 1.
- `tx_valid` input 1: host presents a byte.
- `tx_data` input DATA_WIDTH: byte to send; sampled at acceptance.
- `tx_ready` output 1: high exactly when the FSM is in IDLE.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high in every non-IDLE state.
- `done` output 1: one-cycle pulse when a frame completes.

## Operation

- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - `tx`=1; `tx_ready`=1.
  - When `tx_valid`=1, accept on that edge: latch `tx_data` into the shift register, latch `baud_div` (0 becomes 1) into `div_r`, clear `bit_cnt`, go to START.
- Bit-period counter `cnt_r`:
  - Cleared in IDLE and on every state change.
  - Otherwise increments each cycle.
  - `tick` = (`cnt_r` == `div_r`-1), combinational.
  - On `tick`, `cnt_r` returns to 0.
- START:
  - `tx`=0.
  - On `tick`, go to DATA.
- DATA:
  - `tx` = shift register bit 0.
  - On `tick`: shift right one place and increment `bit_cnt`.
  - When `bit_cnt`==DATA_WIDTH-1 and `tick`, go to PARITY, or to STOP without the macro.
- PARITY:
  - `tx` = XOR of the latched data bits (even parity).
  - On `tick`, go to STOP.
- STOP:
  - `tx`=1.
  - On `tick`, go to IDLE and assert `done` for that single cycle.
- `tx_data`, `baud_div` and `tx_valid` are ignored outside IDLE; changing them mid-frame has no effect.
- `tx` is registered; no glitches.

## Timing

- Reset values:
  - State IDLE; `tx`=1, `busy`=0, `done`=0.
  - `tx_ready`=1 in the first cycle after reset deasserts.
  - `cnt_r`, `bit_cnt` and the shift register all clear to 0.
- Let the accept edge be E and D = `div_r`. Then:
  - `tx` falls to 0 in the cycle after E and holds for D cycles.
  - Each data bit lasts D cycles.
  - Parity, when present, lasts D cycles.
  - Stop lasts D cycles.
- Frame length on the line: F = (DATA_WIDTH+2)·D cycles, or (DATA_WIDTH+3)·D with parity.
- Completion:
  - `done` is high in the cycle in which the FSM returns to IDLE.
  - `tx_ready` rises on the same edge.
- Back-to-back:
  - With `tx_valid` held high, the next accept happens on the first IDLE edge.
  - Accept-to-accept period is F+1 cycles.
  - Consecutive start bits are separated by exactly one extra idle-high cycle.
- `baud_div`=1: every state lasts one cycle; the counter never exceeds 0.
- `rst` asserted mid-frame:
  - Frame is aborted; `tx`=1 on the next edge.
  - No `done` pulse; the latched byte is discarded.
- `rst` and `tx_valid` high in the same cycle: reset wins; the byte is not accepted.

## Configuration

- Macro: `UART_TX_PARITY_EN`.
- When defined:
  - PARITY state is compiled in.
  - Even parity bit follows the last data bit.
  - Frame has DATA_WIDTH+3 bits.
- When undefined:
  - No PARITY state and no parity logic.
  - DATA goes directly to STOP.
  - Frame has DATA_WIDTH+2 bits.

## Test plan

- Reset: hold `rst` 3 cycles mid-frame (`baud_div`=4, byte 0xFF) -> next edge `tx`=1, `busy`=0, `tx_ready`=1, no `done`.
- Single frame, parity on: `baud_div`=4, `tx_data`=0xA5 -> `tx` carries 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles, 44 cycles total; `done` pulses once, 44 cycles after the accept edge.
- Parity off: same stimulus -> parity bit absent; 40 cycles total; `done` 40 cycles after accept.
- Back-to-back: `tx_valid` held high with 0x00 then 0xFF, `baud_div`=2 -> second start bit begins exactly one idle-high cycle after the first stop bit ends; accepts 23 cycles apart with parity.
- Edge divisors and mid-frame changes:
  - `baud_div`=0 and `baud_div`=1 with 0x3C -> one cycle per bit; identical waveforms.
  - Change `baud_div` to 10 mid-frame -> current frame unaffected.
- Handshake hold-off: pulse `tx_valid` with a new byte during DATA -> ignored; `tx_ready`=0 throughout; only the first byte appears on `tx`.
